// File: rtl/rs_pkg.sv
// Shared definitions for the reservation station bank: widths, dispatch word
// layout, dispatch control encodings and the CDB snoop helper.
package rs_pkg;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 5;
  localparam int IN_W   = 2 * DATA_W + 12;

  // Bit offsets of the fields inside the 76-bit dispatch word
  localparam int ALU_CTRL_LSB = 0;
  localparam int RD_LSB       = 5;
  localparam int RS1_V_BIT    = 10;
  localparam int RS1_VT_LSB   = 11;
  localparam int RS2_V_BIT    = 43;
  localparam int RS2_VT_LSB   = 44;

  typedef enum logic [1:0] {
    DISP_BUBBLE  = 2'b00,
    DISP_COMPLEX = 2'b01,
    DISP_FP      = 2'b10,
    DISP_SIMPLE  = 2'b11
  } dispCtrl_e;

  // Same layout as the offsets above, MSB first
  typedef struct packed {
    logic [DATA_W-1:0] rs2Vt;
    logic              rs2V;
    logic [DATA_W-1:0] rs1Vt;
    logic              rs1V;
    logic [4:0]        rd;
    logic [4:0]        aluCtrl;
  } dispWord_t;

  typedef struct packed {
    logic              v;
    logic [DATA_W-1:0] vt;
  } operand_t;

  // Captures a broadcast result into a waiting operand; port a wins a tie
  function automatic operand_t snoop(input operand_t op,
                                     input logic aValid, input logic [TAG_W-1:0] aTag,
                                     input logic [DATA_W-1:0] aData,
                                     input logic bValid, input logic [TAG_W-1:0] bTag,
                                     input logic [DATA_W-1:0] bData);
    operand_t res;
    res = op;
    if (!op.v) begin
      if (aValid && (aTag == op.vt[TAG_W-1:0])) begin
        res.v  = 1'b1;
        res.vt = aData;
      end else if (bValid && (bTag == op.vt[TAG_W-1:0])) begin
        res.v  = 1'b1;
        res.vt = bData;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rs_bank_if.sv
// Dispatch, CDB, flush and issue signals of one reservation station bank.
// The master side is dispatch/CDB/execution unit, the slave side is the bank.
interface rs_bank_if;
  import rs_pkg::*;

  logic [IN_W-1:0]   in_0_data;
  logic              in_0_valid;
  logic [IN_W-1:0]   in_1_data;
  logic              in_1_valid;
  logic              empty_0;
  logic              empty_1;
  logic              cdb_a_valid;
  logic [TAG_W-1:0]  cdb_a_tag;
  logic [DATA_W-1:0] cdb_a_data;
  logic              cdb_b_valid;
  logic [TAG_W-1:0]  cdb_b_tag;
  logic [DATA_W-1:0] cdb_b_data;
  logic              flush;
  logic              issue_valid;
  logic              issue_ready;
  logic [DATA_W-1:0] issue_rs1;
  logic [DATA_W-1:0] issue_rs2;
  logic [4:0]        issue_rd;
  logic [4:0]        issue_alu_ctrl;
  logic              overflow_err;

  modport master (
    output in_0_data, in_0_valid, in_1_data, in_1_valid,
    output cdb_a_valid, cdb_a_tag, cdb_a_data, cdb_b_valid, cdb_b_tag, cdb_b_data,
    output flush, issue_ready,
    input  empty_0, empty_1, issue_valid, issue_rs1, issue_rs2, issue_rd,
    input  issue_alu_ctrl, overflow_err
  );

  modport slave (
    input  in_0_data, in_0_valid, in_1_data, in_1_valid,
    input  cdb_a_valid, cdb_a_tag, cdb_a_data, cdb_b_valid, cdb_b_tag, cdb_b_data,
    input  flush, issue_ready,
    output empty_0, empty_1, issue_valid, issue_rs1, issue_rs2, issue_rd,
    output issue_alu_ctrl, overflow_err
  );

endinterface

// File: rtl/rs_entry.sv
// One reservation station entry: storage, write-cycle bypass and CDB snoop.
module rs_entry
  import rs_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wrEn,
  input  dispWord_t         wrData,
  input  logic              clear,
  input  logic              cdbAValid,
  input  logic [TAG_W-1:0]  cdbATag,
  input  logic [DATA_W-1:0] cdbAData,
  input  logic              cdbBValid,
  input  logic [TAG_W-1:0]  cdbBTag,
  input  logic [DATA_W-1:0] cdbBData,
  output logic              occ,
  output logic              ready,
  output logic [DATA_W-1:0] rs1,
  output logic [DATA_W-1:0] rs2,
  output logic [4:0]        rd,
  output logic [4:0]        aluCtrl
);

  logic     occ_q, occ_d;
  operand_t rs1_q, rs1_d;
  operand_t rs2_q, rs2_d;
  logic [4:0] rd_q, rd_d;
  logic [4:0] alu_q, alu_d;

  // Next state: clear beats a write, a write is snooped as it lands, otherwise snoop held operands
  always_comb begin
    occ_d = occ_q;
    rs1_d = rs1_q;
    rs2_d = rs2_q;
    rd_d  = rd_q;
    alu_d = alu_q;
    if (clear) begin
      occ_d = 1'b0;
    end else if (wrEn) begin
      occ_d = 1'b1;
      rs1_d = snoop({wrData.rs1V, wrData.rs1Vt}, cdbAValid, cdbATag, cdbAData,
                    cdbBValid, cdbBTag, cdbBData);
      rs2_d = snoop({wrData.rs2V, wrData.rs2Vt}, cdbAValid, cdbATag, cdbAData,
                    cdbBValid, cdbBTag, cdbBData);
      rd_d  = wrData.rd;
      alu_d = wrData.aluCtrl;
    end else if (occ_q) begin
      rs1_d = snoop(rs1_q, cdbAValid, cdbATag, cdbAData, cdbBValid, cdbBTag, cdbBData);
      rs2_d = snoop(rs2_q, cdbAValid, cdbATag, cdbAData, cdbBValid, cdbBTag, cdbBData);
    end
  end

  // Entry registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q <= 1'b0;
      rs1_q <= '0;
      rs2_q <= '0;
      rd_q  <= '0;
      alu_q <= '0;
    end else begin
      occ_q <= occ_d;
      rs1_q <= rs1_d;
      rs2_q <= rs2_d;
      rd_q  <= rd_d;
      alu_q <= alu_d;
    end
  end

  assign occ     = occ_q;
  assign ready   = occ_q & rs1_q.v & rs2_q.v;
  assign rs1     = rs1_q.vt;
  assign rs2     = rs2_q.vt;
  assign rd      = rd_q;
  assign aluCtrl = alu_q;

endmodule

// File: rtl/rs_bank.sv
// Two-entry reservation station bank: accepts dispatch writes, wakes operands
// from two CDB ports and issues the oldest ready entry.
module rs_bank
  import rs_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  rs_bank_if.slave  bus
);

  dispWord_t in0Word, in1Word;
  logic wr0En, wr1En, clear0, clear1;
  logic e0Occ, e0Ready, e1Occ, e1Ready;
  logic [DATA_W-1:0] e0Rs1, e0Rs2, e1Rs1, e1Rs2;
  logic [4:0] e0Rd, e0Alu, e1Rd, e1Alu;
  logic sel1, issueValid, fire;
  logic e1Older_q, e1Older_d;
  logic overflow_q, overflow_d;

  assign in0Word = bus.in_0_data;
  assign in1Word = bus.in_1_data;

  // Writes into an occupied entry (including one firing this cycle) are dropped
  assign wr0En  = bus.in_0_valid & ~e0Occ;
  assign wr1En  = bus.in_1_valid & ~e1Occ;
  assign clear0 = bus.flush | (fire & ~sel1);
  assign clear1 = bus.flush | (fire & sel1);

  rs_entry u_entry0 (
    .clk(clk), .reset(reset), .wrEn(wr0En), .wrData(in0Word), .clear(clear0),
    .cdbAValid(bus.cdb_a_valid), .cdbATag(bus.cdb_a_tag), .cdbAData(bus.cdb_a_data),
    .cdbBValid(bus.cdb_b_valid), .cdbBTag(bus.cdb_b_tag), .cdbBData(bus.cdb_b_data),
    .occ(e0Occ), .ready(e0Ready), .rs1(e0Rs1), .rs2(e0Rs2), .rd(e0Rd), .aluCtrl(e0Alu)
  );

  rs_entry u_entry1 (
    .clk(clk), .reset(reset), .wrEn(wr1En), .wrData(in1Word), .clear(clear1),
    .cdbAValid(bus.cdb_a_valid), .cdbATag(bus.cdb_a_tag), .cdbAData(bus.cdb_a_data),
    .cdbBValid(bus.cdb_b_valid), .cdbBTag(bus.cdb_b_tag), .cdbBData(bus.cdb_b_data),
    .occ(e1Occ), .ready(e1Ready), .rs1(e1Rs1), .rs2(e1Rs2), .rd(e1Rd), .aluCtrl(e1Alu)
  );

  // Oldest-ready select and issue mux, driven only from entry registers
  always_comb begin
    issueValid         = e0Ready | e1Ready;
    sel1               = e1Ready & (~e0Ready | e1Older_q);
    fire               = issueValid & bus.issue_ready;
    bus.issue_rs1      = '0;
    bus.issue_rs2      = '0;
    bus.issue_rd       = '0;
    bus.issue_alu_ctrl = '0;
    if (issueValid) begin
      bus.issue_rs1      = sel1 ? e1Rs1 : e0Rs1;
      bus.issue_rs2      = sel1 ? e1Rs2 : e0Rs2;
      bus.issue_rd       = sel1 ? e1Rd  : e0Rd;
      bus.issue_alu_ctrl = sel1 ? e1Alu : e0Alu;
    end
  end

  // Age tracking and sticky overflow detection
  always_comb begin
    e1Older_d  = e1Older_q;
    overflow_d = overflow_q | (bus.in_0_valid & e0Occ) | (bus.in_1_valid & e1Occ);
    if (!bus.flush) begin
      if (wr0En && wr1En) begin
        e1Older_d = 1'b1;
      end else if (wr0En && e1Occ) begin
        e1Older_d = 1'b1;
      end else if (wr1En && e0Occ) begin
        e1Older_d = 1'b0;
      end
    end
  end

  // Age and error registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e1Older_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      e1Older_q  <= e1Older_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.issue_valid  = issueValid;
  assign bus.empty_0      = ~e0Occ;
  assign bus.empty_1      = ~e1Occ;
  assign bus.overflow_err = overflow_q;

endmodule

// File: tb/tb_rs_bank.sv
// Directed testbench for the two-entry reservation station bank.
module tb_rs_bank;

  logic clk;
  logic reset;
  int checks;
  int errors;

  rs_bank_if bus ();

  rs_bank dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Dispatch word {rs2_vt, rs2_v, rs1_vt, rs1_v, rd, alu_ctrl}
  function automatic logic [75:0] mkWord(input logic rs2v, input logic [31:0] rs2,
                                         input logic rs1v, input logic [31:0] rs1,
                                         input logic [4:0] rd, input logic [4:0] alu);
    return {rs2, rs2v, rs1, rs1v, rd, alu};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_0_valid  = 1'b0;
    bus.in_1_valid  = 1'b0;
    bus.in_0_data   = '0;
    bus.in_1_data   = '0;
    bus.cdb_a_valid = 1'b0;
    bus.cdb_a_tag   = '0;
    bus.cdb_a_data  = '0;
    bus.cdb_b_valid = 1'b0;
    bus.cdb_b_tag   = '0;
    bus.cdb_b_data  = '0;
    bus.flush       = 1'b0;
    bus.issue_ready = 1'b0;
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (bus.empty_0 !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty0: got %b expected 1", bus.empty_0); end
    checks++; if (bus.empty_1 !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty1: got %b expected 1", bus.empty_1); end
    checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.issue_valid); end
    checks++; if (bus.issue_rs1 !== 32'h0) begin errors++; $display("[TB] FAIL reset_rs1: got %h expected 0", bus.issue_rs1); end
    checks++; if (bus.overflow_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf: got %b expected 0", bus.overflow_err); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_issue();
    bus.in_1_data  = mkWord(1'b1, 32'd7, 1'b1, 32'd5, 5'd3, 5'd2);
    bus.in_1_valid = 1'b1;
    tick();
    bus.in_1_valid = 1'b0;
    checks++; if (bus.empty_1 !== 1'b0) begin errors++; $display("[TB] FAIL single_empty1: got %b expected 0", bus.empty_1); end
    checks++; if (bus.issue_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid: got %b expected 1", bus.issue_valid); end
    checks++; if (bus.issue_rs1 !== 32'd5) begin errors++; $display("[TB] FAIL single_rs1: got %0d expected 5", bus.issue_rs1); end
    checks++; if (bus.issue_rs2 !== 32'd7) begin errors++; $display("[TB] FAIL single_rs2: got %0d expected 7", bus.issue_rs2); end
    checks++; if (bus.issue_rd !== 5'd3) begin errors++; $display("[TB] FAIL single_rd: got %0d expected 3", bus.issue_rd); end
    checks++; if (bus.issue_alu_ctrl !== 5'd2) begin errors++; $display("[TB] FAIL single_alu: got %0d expected 2", bus.issue_alu_ctrl); end
    bus.issue_ready = 1'b1;
    tick();
    bus.issue_ready = 1'b0;
    checks++; if (bus.empty_1 !== 1'b1) begin errors++; $display("[TB] FAIL single_free: got %b expected 1", bus.empty_1); end
    checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_drained: got %b expected 0", bus.issue_valid); end
  endtask

  task automatic test_wakeup();
    bus.in_0_data  = mkWord(1'b0, 32'd9, 1'b1, 32'h11, 5'd4, 5'd1);
    bus.in_0_valid = 1'b1;
    tick();
    bus.in_0_valid = 1'b0;
    checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("[TB] FAIL wake_wait: got %b expected 0", bus.issue_valid); end
    checks++; if (bus.empty_0 !== 1'b0) begin errors++; $display("[TB] FAIL wake_empty0: got %b expected 0", bus.empty_0); end
    bus.cdb_a_valid = 1'b1;
    bus.cdb_a_tag   = 5'd8;
    bus.cdb_a_data  = 32'h5555;
    tick();
    bus.cdb_a_valid = 1'b0;
    checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("[TB] FAIL wake_wrongtag: got %b expected 0", bus.issue_valid); end
    bus.cdb_b_valid = 1'b1;
    bus.cdb_b_tag   = 5'd9;
    bus.cdb_b_data  = 32'hDEAD;
    tick();
    bus.cdb_b_valid = 1'b0;
    checks++; if (bus.issue_valid !== 1'b1) begin errors++; $display("[TB] FAIL wake_valid: got %b expected 1", bus.issue_valid); end
    checks++; if (bus.issue_rs2 !== 32'hDEAD) begin errors++; $display("[TB] FAIL wake_rs2: got %h expected dead", bus.issue_rs2); end
    checks++; if (bus.issue_rs1 !== 32'h11) begin errors++; $display("[TB] FAIL wake_rs1: got %h expected 11", bus.issue_rs1); end
    bus.issue_ready = 1'b1;
    tick();
    bus.issue_ready = 1'b0;
    checks++; if (bus.empty_0 !== 1'b1) begin errors++; $display("[TB] FAIL wake_free: got %b expected 1", bus.empty_0); end
  endtask

  task automatic test_back_to_back();
    bus.in_0_data   = mkWord(1'b1, 32'h0, 1'b1, 32'h100, 5'd10, 5'd0);
    bus.in_1_data   = mkWord(1'b1, 32'h0, 1'b1, 32'h200, 5'd11, 5'd0);
    bus.in_0_valid  = 1'b1;
    bus.in_1_valid  = 1'b1;
    bus.issue_ready = 1'b1;
    tick();
    bus.in_0_valid = 1'b0;
    bus.in_1_valid = 1'b0;
    checks++; if (bus.issue_rd !== 5'd11) begin errors++; $display("[TB] FAIL b2b_first: got %0d expected 11", bus.issue_rd); end
    tick();
    checks++; if (bus.issue_rd !== 5'd10) begin errors++; $display("[TB] FAIL b2b_second_rd: got %0d expected 10", bus.issue_rd); end
    checks++; if (bus.issue_rs1 !== 32'h100) begin errors++; $display("[TB] FAIL b2b_second_rs1: got %h expected 100", bus.issue_rs1); end
    tick();
    checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drained: got %b expected 0", bus.issue_valid); end
    bus.issue_ready = 1'b0;
    bus.in_0_valid  = 1'b1;
    bus.in_1_valid  = 1'b1;
    tick();
    bus.in_0_valid = 1'b0;
    bus.in_1_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.issue_rd !== 5'd11 || bus.issue_rs1 !== 32'h200 || bus.issue_valid !== 1'b1) begin
        errors++; $display("[TB] FAIL hold_%0d: got valid %b rd %0d rs1 %h expected 1 11 200", i, bus.issue_valid, bus.issue_rd, bus.issue_rs1);
      end
      tick();
    end
    bus.issue_ready = 1'b1;
    tick();
    tick();
    bus.issue_ready = 1'b0;
    checks++; if (bus.empty_0 !== 1'b1 || bus.empty_1 !== 1'b1) begin errors++; $display("[TB] FAIL hold_drain: got %b%b expected 11", bus.empty_0, bus.empty_1); end
  endtask

  task automatic test_age();
    bus.in_1_data  = mkWord(1'b0, 32'd3, 1'b1, 32'h31, 5'd12, 5'd0);
    bus.in_1_valid = 1'b1;
    tick();
    bus.in_1_valid = 1'b0;
    bus.in_0_data  = mkWord(1'b1, 32'h2, 1'b1, 32'h41, 5'd13, 5'd0);
    bus.in_0_valid = 1'b1;
    tick();
    bus.in_0_valid = 1'b0;
    checks++; if (bus.issue_rd !== 5'd13) begin errors++; $display("[TB] FAIL age_only_ready: got %0d expected 13", bus.issue_rd); end
    bus.cdb_a_valid = 1'b1;
    bus.cdb_a_tag   = 5'd3;
    bus.cdb_a_data  = 32'h55;
    tick();
    bus.cdb_a_valid = 1'b0;
    checks++; if (bus.issue_rd !== 5'd12) begin errors++; $display("[TB] FAIL age_older_wins: got %0d expected 12", bus.issue_rd); end
    checks++; if (bus.issue_rs2 !== 32'h55) begin errors++; $display("[TB] FAIL age_rs2: got %h expected 55", bus.issue_rs2); end
    bus.issue_ready = 1'b1;
    tick();
    checks++; if (bus.issue_rd !== 5'd13) begin errors++; $display("[TB] FAIL age_next: got %0d expected 13", bus.issue_rd); end
    tick();
    bus.issue_ready = 1'b0;
    checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("[TB] FAIL age_drained: got %b expected 0", bus.issue_valid); end
  endtask

  task automatic test_bypass();
    bus.in_0_data   = mkWord(1'b0, 32'd6, 1'b0, 32'd6, 5'd7, 5'd5);
    bus.in_0_valid  = 1'b1;
    bus.cdb_a_valid = 1'b1;
    bus.cdb_a_tag   = 5'd6;
    bus.cdb_a_data  = 32'hBEEF;
    bus.cdb_b_valid = 1'b1;
    bus.cdb_b_tag   = 5'd6;
    bus.cdb_b_data  = 32'h1234;
    tick();
    idle();
    checks++; if (bus.issue_valid !== 1'b1) begin errors++; $display("[TB] FAIL bypass_valid: got %b expected 1", bus.issue_valid); end
    checks++; if (bus.issue_rs1 !== 32'hBEEF) begin errors++; $display("[TB] FAIL bypass_rs1: got %h expected beef", bus.issue_rs1); end
    checks++; if (bus.issue_rs2 !== 32'hBEEF) begin errors++; $display("[TB] FAIL bypass_porta: got %h expected beef", bus.issue_rs2); end
    bus.issue_ready = 1'b1;
    tick();
    bus.issue_ready = 1'b0;
  endtask

  task automatic test_overflow();
    bus.in_1_data  = mkWord(1'b1, 32'h1, 1'b1, 32'hAA, 5'd20, 5'd0);
    bus.in_1_valid = 1'b1;
    tick();
    checks++; if (bus.overflow_err !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clean: got %b expected 0", bus.overflow_err); end
    bus.in_1_data = mkWord(1'b1, 32'h1, 1'b1, 32'hBB, 5'd21, 5'd0);
    tick();
    bus.in_1_valid = 1'b0;
    checks++; if (bus.overflow_err !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set: got %b expected 1", bus.overflow_err); end
    checks++; if (bus.issue_rd !== 5'd20 || bus.issue_rs1 !== 32'hAA) begin errors++; $display("[TB] FAIL ovf_data: got rd %0d rs1 %h expected 20 aa", bus.issue_rd, bus.issue_rs1); end
    tick();
    checks++; if (bus.overflow_err !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky: got %b expected 1", bus.overflow_err); end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.empty_1 !== 1'b1 || bus.issue_valid !== 1'b0 || bus.overflow_err !== 1'b0 || bus.issue_rs1 !== 32'h0) begin
      errors++; $display("[TB] FAIL async_reset: got empty1 %b valid %b ovf %b rs1 %h expected 1 0 0 0", bus.empty_1, bus.issue_valid, bus.overflow_err, bus.issue_rs1);
    end
    #1 reset = 1'b0;
    tick();
  endtask

  task automatic test_fire_write_conflict();
    bus.in_1_data  = mkWord(1'b1, 32'h1, 1'b1, 32'h77, 5'd22, 5'd0);
    bus.in_1_valid = 1'b1;
    tick();
    bus.issue_ready = 1'b1;
    bus.in_1_data   = mkWord(1'b1, 32'h1, 1'b1, 32'h88, 5'd23, 5'd0);
    tick();
    bus.in_1_valid  = 1'b0;
    bus.issue_ready = 1'b0;
    checks++; if (bus.overflow_err !== 1'b1) begin errors++; $display("[TB] FAIL conflict_ovf: got %b expected 1", bus.overflow_err); end
    checks++; if (bus.empty_1 !== 1'b1) begin errors++; $display("[TB] FAIL conflict_dropped: got %b expected 1", bus.empty_1); end
    pulseReset();
  endtask

  task automatic test_flush();
    bus.in_0_data  = mkWord(1'b1, 32'h2, 1'b1, 32'h3, 5'd1, 5'd0);
    bus.in_1_data  = mkWord(1'b0, 32'd4, 1'b1, 32'h3, 5'd2, 5'd0);
    bus.in_0_valid = 1'b1;
    bus.in_1_valid = 1'b1;
    tick();
    bus.in_0_valid = 1'b0;
    bus.in_1_valid = 1'b0;
    checks++; if (bus.issue_valid !== 1'b1) begin errors++; $display("[TB] FAIL flush_pre: got %b expected 1", bus.issue_valid); end
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid: got %b expected 0", bus.issue_valid); end
    checks++; if (bus.empty_0 !== 1'b1 || bus.empty_1 !== 1'b1) begin errors++; $display("[TB] FAIL flush_empty: got %b%b expected 11", bus.empty_0, bus.empty_1); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    idle();
    test_reset();
    test_single_issue();
    test_wakeup();
    test_back_to_back();
    test_age();
    test_bypass();
    test_overflow();
    test_fire_write_conflict();
    test_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
